alu_operand_loader: RTL and testbench

//   Front-end stage that feeds the TP1 ALU from board switches and push-buttons.

---
 rtl/alu_operand_loader_if.sv | 23 ++
 rtl/alu_operand_loader.sv | 94 +++++++++
 tb/tb_alu_operand_loader.sv | 132 +++++++++++++
 3 files changed

// File: rtl/alu_operand_loader_if.sv
// alu_operand_loader_if: switch/button inputs and ALU operation handshake
interface alu_operand_loader_if #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
);
  logic [NB_DATA-1:0] i_sw;
  logic               i_btn_load;
  logic               i_btn_clear;
  logic               i_ready;
  logic [NB_DATA-1:0] o_data_a;
  logic [NB_DATA-1:0] o_data_b;
  logic [NB_OP-1:0]   o_op;
  logic               o_valid;
  logic [1:0]         o_state;
  modport master (
    input  i_sw, i_btn_load, i_btn_clear, i_ready,
    output o_data_a, o_data_b, o_op, o_valid, o_state
  );
  modport slave (
    output i_sw, i_btn_load, i_btn_clear, i_ready,
    input  o_data_a, o_data_b, o_op, o_valid, o_state
  );
endinterface

// File: rtl/alu_operand_loader.sv
// alu_operand_loader: debounced LOAD/CLEAR sequencer presenting A, B and opcode to the ALU
module alu_operand_loader #(
  parameter int NB_DATA         = 8,
  parameter int NB_OP           = 6,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int NB_DBC          = 20
) (
  input logic                 i_clk,
  input logic                 i_reset,
  alu_operand_loader_if.master bus
);
  typedef enum logic [1:0] {LOAD_A = 2'b00, LOAD_B = 2'b01, LOAD_OP = 2'b10, ISSUE = 2'b11} state_t;
  localparam logic [NB_DBC-1:0] CNT_MAX = NB_DBC'(DEBOUNCE_CYCLES - 1);
  logic [1:0]        raw;
  logic [1:0]        sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]        stable_q, stable_d, press_q, press_d, flip;
  logic [NB_DBC-1:0] cnt_q [2];
  logic [NB_DBC-1:0] cnt_d [2];
  state_t            state_q, state_d;
  logic [NB_DATA-1:0] data_a_q, data_a_d, data_b_q, data_b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic               valid_q, valid_d;
  logic               ld, clr;
  // bit 0 is LOAD, bit 1 is CLEAR; both share the same sync/debounce path
  assign raw = {bus.i_btn_clear, bus.i_btn_load};
  assign ld  = press_q[0];
  assign clr = press_q[1];
  // synchronise, debounce and edge-detect each button; the press pulse is registered
  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    for (int i = 0; i < 2; i++) begin
      flip[i]     = (sync2_q[i] != stable_q[i]) && (cnt_q[i] == CNT_MAX);
      stable_d[i] = flip[i] ? sync2_q[i] : stable_q[i];
      press_d[i]  = flip[i] & sync2_q[i];
      cnt_d[i]    = (sync2_q[i] == stable_q[i] || flip[i]) ? '0 : cnt_q[i] + NB_DBC'(1);
    end
  end
  // input path registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      press_q  <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end
  // sequencer state register
  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= LOAD_A;
    else state_q <= state_d;
  end
  // next state: CLEAR overrides everything; LOAD presses in ISSUE are ignored
  always_comb begin
    state_d = state_q;
    if (clr) state_d = LOAD_A;
    else if (state_q == ISSUE) state_d = (valid_q && bus.i_ready) ? LOAD_A : ISSUE;
    else if (ld) state_d = state_t'(state_q + 2'd1);
  end
  // operand/opcode capture and valid generation
  always_comb begin
    data_a_d = clr ? '0 : (ld && state_q == LOAD_A) ? bus.i_sw : data_a_q;
    data_b_d = clr ? '0 : (ld && state_q == LOAD_B) ? bus.i_sw : data_b_q;
    op_d     = clr ? '0 : (ld && state_q == LOAD_OP) ? bus.i_sw[NB_DATA-1 -: NB_OP] : op_q;
    valid_d  = clr ? 1'b0 : (ld && state_q == LOAD_OP) ? 1'b1 : (valid_q && bus.i_ready) ? 1'b0 : valid_q;
  end
  // output registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      data_a_q <= '0;
      data_b_q <= '0;
      op_q     <= '0;
      valid_q  <= 1'b0;
    end else begin
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
      op_q     <= op_d;
      valid_q  <= valid_d;
    end
  end
  assign bus.o_data_a = data_a_q;
  assign bus.o_data_b = data_b_q;
  assign bus.o_op     = op_q;
  assign bus.o_valid  = valid_q;
  assign bus.o_state  = state_q;
endmodule

// File: tb/tb_alu_operand_loader.sv
// tb_alu_operand_loader: directed scoreboard bench for alu_operand_loader
module tb_alu_operand_loader;
  typedef struct packed {logic [7:0] a; logic [7:0] b; logic [5:0] op;} exp_t;
  logic i_clk = 1'b0;
  logic i_reset = 1'b1;
  int checks = 0;
  int failures = 0;
  exp_t q[$];
  alu_operand_loader_if #(.NB_DATA(8), .NB_OP(6)) bus ();
  alu_operand_loader #(.NB_DATA(8), .NB_OP(6), .DEBOUNCE_CYCLES(4), .NB_DBC(20)) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .bus(bus)
  );
  always #5 i_clk = ~i_clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic press(input bit is_clr, input logic [7:0] sw);
    @(negedge i_clk);
    bus.i_sw = sw;
    if (is_clr) bus.i_btn_clear = 1'b1;
    else bus.i_btn_load = 1'b1;
    repeat (10) @(negedge i_clk);
    bus.i_btn_load = 1'b0;
    bus.i_btn_clear = 1'b0;
    repeat (10) @(negedge i_clk);
  endtask
  task automatic wait_valid(input string tag);
    int n = 0;
    exp_t e;
    while (!bus.o_valid && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(bus.o_valid), 1);
    chk({tag, "_sb_nonempty"}, 32'(q.size() != 0), 1);
    if (q.size() != 0) begin
      e = q.pop_front();
      chk({tag, "_a"}, 32'(bus.o_data_a), 32'(e.a));
      chk({tag, "_b"}, 32'(bus.o_data_b), 32'(e.b));
      chk({tag, "_op"}, 32'(bus.o_op), 32'(e.op));
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_a"}, 32'(bus.o_data_a), 0);
    chk({tag, "_b"}, 32'(bus.o_data_b), 0);
    chk({tag, "_op"}, 32'(bus.o_op), 0);
    chk({tag, "_valid"}, 32'(bus.o_valid), 0);
    chk({tag, "_state"}, 32'(bus.o_state), 0);
  endtask
  initial begin
    bus.i_sw = '0;
    bus.i_btn_load = 1'b0;
    bus.i_btn_clear = 1'b0;
    bus.i_ready = 1'b0;
    repeat (3) @(negedge i_clk);
    chk_zero("reset");
    i_reset = 1'b0;
    press(1'b0, 8'h05);
    chk("t1_state_b", 32'(bus.o_state), 1);
    chk("t1_a", 32'(bus.o_data_a), 32'h05);
    press(1'b0, 8'h03);
    chk("t1_state_op", 32'(bus.o_state), 2);
    chk("t1_b", 32'(bus.o_data_b), 32'h03);
    q.push_back('{a: 8'h05, b: 8'h03, op: 6'b100000});
    press(1'b0, 8'h80);
    chk("t1_state_issue", 32'(bus.o_state), 3);
    wait_valid("t1");
    bus.i_ready = 1'b1;
    @(negedge i_clk);
    bus.i_ready = 1'b0;
    chk("t1_acc_valid", 32'(bus.o_valid), 0);
    chk("t1_acc_state", 32'(bus.o_state), 0);
    chk("t1_acc_a_kept", 32'(bus.o_data_a), 32'h05);
    bus.i_sw = 8'h11;
    for (int i = 0; i < 3; i++) begin
      bus.i_btn_load = 1'b1;
      repeat (2) @(negedge i_clk);
      bus.i_btn_load = 1'b0;
      repeat (2) @(negedge i_clk);
    end
    repeat (4) @(negedge i_clk);
    chk("t2_bounce_state", 32'(bus.o_state), 0);
    press(1'b0, 8'h11);
    chk("t2_once_state", 32'(bus.o_state), 1);
    chk("t2_a", 32'(bus.o_data_a), 32'h11);
    press(1'b0, 8'h22);
    q.push_back('{a: 8'h11, b: 8'h22, op: 6'h10});
    press(1'b0, 8'h40);
    press(1'b0, 8'hFF);
    press(1'b0, 8'hFF);
    chk("t3_valid", 32'(bus.o_valid), 1);
    chk("t3_state", 32'(bus.o_state), 3);
    wait_valid("t3");
    bus.i_ready = 1'b1;
    @(negedge i_clk);
    bus.i_ready = 1'b0;
    chk("t3_acc_state", 32'(bus.o_state), 0);
    press(1'b0, 8'h05);
    press(1'b0, 8'h03);
    chk("t4_pre_state", 32'(bus.o_state), 2);
    press(1'b1, 8'h00);
    chk_zero("t4_clear");
    @(negedge i_clk);
    bus.i_sw = 8'h77;
    bus.i_btn_load = 1'b1;
    bus.i_btn_clear = 1'b1;
    repeat (10) @(negedge i_clk);
    bus.i_btn_load = 1'b0;
    bus.i_btn_clear = 1'b0;
    repeat (10) @(negedge i_clk);
    chk("t5_state", 32'(bus.o_state), 0);
    chk("t5_a", 32'(bus.o_data_a), 0);
    press(1'b0, 8'hA5);
    press(1'b0, 8'h5A);
    q.push_back('{a: 8'hA5, b: 8'h5A, op: 6'h3F});
    press(1'b0, 8'hFC);
    wait_valid("t6");
    i_reset = 1'b1;
    @(negedge i_clk);
    i_reset = 1'b0;
    chk_zero("t6_reset");
    chk("sb_empty", 32'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
